lsu: RTL and testbench



---
 rtl/lsu_if.sv | 38 +++
 rtl/lsu.sv | 166 ++++++++++++++++
 tb/tb_lsu.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Core-request / bus handshake bundle for the load-store unit.
// The slave modport is the LSU's view; master is the core-and-memory side.
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 15
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN/8-1:0] bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load-store unit: one outstanding access, lane steering, load extension, rvalid timeout.
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned H/W/D accesses instead of aligning them down.
module lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 16
) (
  input logic   clk,
  input logic   rst_n,
  lsu_if.slave  io
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_reg;
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic              resp_err_reg;
  logic [XLEN-1:0]   resp_rdata_reg;
  logic              bus_req_reg;
  logic              bus_we_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [NB-1:0]     bus_be_reg;
  logic [XLEN-1:0]   bus_wdata_reg;
  logic [2:0]        op_reg;
  logic [OFFW-1:0]   off_reg;
  logic [CNTW-1:0]   cnt_reg;

  logic [1:0]        size_lg;
  logic [OFFW-1:0]   size_mask;
  logic [OFFW-1:0]   req_off;
  logic [OFFW-1:0]   off_al;
  logic [NB-1:0]     be_next;
  logic [XLEN-1:0]   wdata_rep;
  logic              illegal_op;
  logic              reject;
  logic [XLEN-1:0]   rd_shift;
  logic [XLEN-1:0]   load_ext;

  assign size_lg    = io.req_op[1:0];
  assign size_mask  = OFFW'((32'd1 << size_lg) - 32'd1);
  assign req_off    = io.req_addr[OFFW-1:0];
  assign off_al     = req_off & ~size_mask;
  assign be_next    = NB'((32'd1 << (32'd1 << size_lg)) - 32'd1) << off_al;
  assign illegal_op = (io.req_op == 3'b111) || (io.req_we && io.req_op[2]) ||
                      ((XLEN == 32) && (io.req_op == 3'b011 || io.req_op == 3'b110));

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject = illegal_op || (|(req_off & size_mask));
`else
  assign reject = illegal_op;
`endif

  // Each byte lane takes the source byte at (lane index modulo access size).
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [OFFW-1:0] src;
      assign src = OFFW'(gi) & size_mask;
      assign wdata_rep[8*gi +: 8] = io.req_wdata[{src, 3'b000} +: 8];
    end
  endgenerate

  assign rd_shift = io.bus_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_ext = rd_shift;
    case (op_reg)
      3'b000:  load_ext = XLEN'($signed(rd_shift[7:0]));
      3'b001:  load_ext = XLEN'($signed(rd_shift[15:0]));
      3'b010:  load_ext = XLEN'($signed(rd_shift[31:0]));
      3'b100:  load_ext = XLEN'(rd_shift[7:0]);
      3'b101:  load_ext = XLEN'(rd_shift[15:0]);
      3'b110:  load_ext = XLEN'(rd_shift[31:0]);
      default: load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= '0;
      bus_be_reg     <= '0;
      bus_wdata_reg  <= '0;
      op_reg         <= '0;
      off_reg        <= '0;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (io.req_valid) begin
            req_ready_reg <= 1'b0;
            op_reg        <= io.req_op;
            off_reg       <= off_al;
            if (reject) begin
              state_reg      <= DONE;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
            end else begin
              state_reg     <= REQ;
              bus_req_reg   <= 1'b1;
              bus_we_reg    <= io.req_we;
              bus_addr_reg  <= {io.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
              bus_be_reg    <= be_next;
              bus_wdata_reg <= io.req_we ? wdata_rep : '0;
            end
          end
        end
        REQ: begin
          if (io.bus_gnt) begin
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_be_reg    <= '0;
            bus_wdata_reg <= '0;
            if (bus_we_reg) begin
              state_reg      <= DONE;
              resp_valid_reg <= 1'b1;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= '0;
            end
          end
        end
        WAIT: begin
          if (io.bus_rvalid) begin
            state_reg      <= DONE;
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= load_ext;
          end else if (cnt_reg == CNTW'(TIMEOUT - 1)) begin
            state_reg      <= DONE;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign io.req_ready  = req_ready_reg;
  assign io.resp_valid = resp_valid_reg;
  assign io.resp_err   = resp_err_reg;
  assign io.resp_rdata = resp_rdata_reg;
  assign io.bus_req    = bus_req_reg;
  assign io.bus_we     = bus_we_reg;
  assign io.bus_addr   = bus_addr_reg;
  assign io.bus_be     = bus_be_reg;
  assign io.bus_wdata  = bus_wdata_reg;
endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: each access is predicted from byte-lane arithmetic and checked cycle by cycle.
module tb_lsu;
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 15;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) io ();

  lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_rdata = '0;
  logic [3:0]  last_be    = '0;
  logic [31:0] last_wd    = '0;
  logic [14:0] last_addr  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"},  64'(io.req_ready),  64'd1);
    check({pfx, "_resp_valid"}, 64'(io.resp_valid), 64'd0);
    check({pfx, "_resp_err"},   64'(io.resp_err),   64'd0);
    check({pfx, "_resp_rdata"}, 64'(io.resp_rdata), 64'd0);
    check({pfx, "_bus_req"},    64'(io.bus_req),    64'd0);
    check({pfx, "_bus_we"},     64'(io.bus_we),     64'd0);
    check({pfx, "_bus_be"},     64'(io.bus_be),     64'd0);
    check({pfx, "_bus_addr"},   64'(io.bus_addr),   64'd0);
    check({pfx, "_bus_wdata"},  64'(io.bus_wdata),  64'd0);
  endtask

  // Expected load value: take sz bytes starting at byte aoff, then sign- or zero-extend.
  function automatic logic [31:0] model_load(input logic [2:0] op, input int aoff, input logic [31:0] word);
    int     sz;
    longint v;
    longint full;
    sz = 1 << op[1:0];
    v  = longint'(word >> (8 * aoff));
    if (sz < 4) begin
      full = longint'(1) << (8 * sz);
      v = v % full;
      if (!op[2] && v >= full / 2) v = v - full;
    end
    return v[31:0];
  endfunction

  task automatic run_access(input bit we, input logic [2:0] op, input logic [14:0] addr,
                            input logic [31:0] wd, input int gd, input int rd,
                            input logic [31:0] rword, input bit noisy);
    int          sz, off, aoff, lim;
    bit          rej, tmo;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd;
    logic [14:0] eaddr;
    sz   = 1 << op[1:0];
    off  = int'(addr[1:0]);
    aoff = (off / sz) * sz;
    rej  = (op == 3'd7) || (op == 3'd3) || (op == 3'd6) || (we && op[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if (off % sz != 0) rej = 1'b1;
`endif
    eaddr = addr - 15'(off);
    ebe   = '0;
    for (int i = 0; i < sz && aoff + i < 4; i++) ebe[aoff + i] = 1'b1;
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
    erd = model_load(op, aoff, rword);
    tmo = (rd >= TIMEOUT);

    check("ready_idle", 64'(io.req_ready), 64'd1);
    io.req_valid  = 1'b1;
    io.req_we     = we;
    io.req_op     = op;
    io.req_addr   = addr;
    io.req_wdata  = wd;
    io.bus_rvalid = noisy ? 1'($urandom % 2) : 1'b0;
    io.bus_rdata  = $urandom;
    @(negedge clk);
    io.req_valid  = 1'b0;
    io.bus_rvalid = 1'b0;
    check("ready_busy", 64'(io.req_ready), 64'd0);

    if (rej) begin
      check("rej_valid",  64'(io.resp_valid), 64'd1);
      check("rej_err",    64'(io.resp_err),   64'd1);
      check("rej_rdata",  64'(io.resp_rdata), 64'd0);
      check("rej_busreq", 64'(io.bus_req),    64'd0);
      last_rdata = io.resp_rdata;
    end else begin
      for (int k = 0; k <= gd; k++) begin
        check("req_busreq", 64'(io.bus_req),    64'd1);
        check("req_addr",   64'(io.bus_addr),   64'(eaddr));
        check("req_we",     64'(io.bus_we),     64'(we));
        check("req_quiet",  64'(io.resp_valid), 64'd0);
        if (we) begin
          check("req_be", 64'(io.bus_be),    64'(ebe));
          check("req_wd", 64'(io.bus_wdata), 64'(ewd));
        end
        if (k == 0) begin
          last_be   = io.bus_be;
          last_wd   = io.bus_wdata;
          last_addr = io.bus_addr;
        end
        io.bus_gnt    = (k == gd);
        io.bus_rvalid = noisy ? 1'($urandom % 2) : 1'b0;
        io.bus_rdata  = $urandom;
        @(negedge clk);
      end
      io.bus_gnt    = 1'b0;
      io.bus_rvalid = 1'b0;
      if (!we) begin
        lim = tmo ? TIMEOUT - 1 : rd;
        for (int j = 0; j <= lim; j++) begin
          check("wait_quiet",  64'(io.resp_valid), 64'd0);
          check("wait_busreq", 64'(io.bus_req),    64'd0);
          io.bus_rvalid = (j == rd);
          io.bus_rdata  = (j == rd) ? rword : $urandom;
          @(negedge clk);
        end
        io.bus_rvalid = 1'b0;
      end
      check("done_valid", 64'(io.resp_valid), 64'd1);
      check("done_err",   64'(io.resp_err),   64'(!we && tmo));
      check("done_rdata", 64'(io.resp_rdata), (we || tmo) ? 64'd0 : 64'(erd));
      last_rdata = io.resp_rdata;
    end
    check("done_ready", 64'(io.req_ready), 64'd0);
    @(negedge clk);
    check("after_ready", 64'(io.req_ready),  64'd1);
    check("after_valid", 64'(io.resp_valid), 64'd0);
    $display("txn we=%0d op=%0d addr=%h wdata=%h gnt_dly=%0d rv_dly=%0d resp_rdata=%h",
             we, op, addr, wd, gd, rd, last_rdata);
  endtask

  initial begin
    io.req_valid  = 1'b0;
    io.req_we     = 1'b0;
    io.req_op     = '0;
    io.req_addr   = '0;
    io.req_wdata  = '0;
    io.bus_gnt    = 1'b0;
    io.bus_rvalid = 1'b0;
    io.bus_rdata  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Word store, granted at once.
    run_access(1'b1, 3'd2, 15'h0010, 32'h11223344, 0, 0, 32'h0, 1'b0);
    check("sw_be", 64'(last_be), 64'hF);
    // Byte store to lane 3, then signed and unsigned byte loads.
    run_access(1'b1, 3'd0, 15'h0013, 32'h000000AB, 1, 0, 32'h0, 1'b0);
    check("sb_wd", 64'(last_wd), 64'hABABABAB);
    check("sb_be", 64'(last_be), 64'h8);
    run_access(1'b0, 3'd0, 15'h0013, 32'h0, 0, 1, 32'hAB000000, 1'b0);
    check("lb_rdata", 64'(last_rdata), 64'hFFFFFFAB);
    run_access(1'b0, 3'd4, 15'h0013, 32'h0, 0, 0, 32'hAB000000, 1'b0);
    check("lbu_rdata", 64'(last_rdata), 64'h000000AB);
    // Delayed grant and read data.
    run_access(1'b0, 3'd2, 15'h0020, 32'h0, 3, 2, 32'hCAFEF00D, 1'b0);
    check("lw_rdata", 64'(last_rdata), 64'hCAFEF00D);
    // Missing read data times out.
    run_access(1'b0, 3'd2, 15'h0024, 32'h0, 0, 99, 32'h12345678, 1'b0);
    // Misaligned halfword load.
    run_access(1'b0, 3'd1, 15'h0001, 32'h0, 0, 0, 32'h12348001, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh_mis_rdata", 64'(last_rdata), 64'h0);
`else
    check("lh_mis_addr",  64'(last_addr),  64'h0);
    check("lh_mis_rdata", 64'(last_rdata), 64'hFFFF8001);
`endif
    // Illegal encodings.
    run_access(1'b0, 3'd7, 15'h0040, 32'h0, 0, 0, 32'h0, 1'b0);
    run_access(1'b1, 3'd4, 15'h0040, 32'h55, 0, 0, 32'h0, 1'b0);
    run_access(1'b0, 3'd3, 15'h0040, 32'h0, 0, 0, 32'h0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      run_access(1'($urandom % 2), 3'($urandom % 8), 15'($urandom), $urandom,
                 int'($urandom % 4), ($urandom % 10 == 0) ? 20 : int'($urandom % 4),
                 $urandom, 1'b1);
    end

    // Reset pulsed while a load waits for data.
    io.req_valid = 1'b1;
    io.req_we    = 1'b0;
    io.req_op    = 3'd2;
    io.req_addr  = 15'h0100;
    @(negedge clk);
    io.req_valid = 1'b0;
    io.bus_gnt   = 1'b1;
    @(negedge clk);
    io.bus_gnt   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    io.bus_rvalid = 1'b1;
    io.bus_rdata  = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_resp", 64'(io.resp_valid), 64'd0);
      check("post_rst_ready",   64'(io.req_ready),  64'd1);
    end
    io.bus_rvalid = 1'b0;
    $display("txn reset_during_wait addr=0100");
    run_access(1'b0, 3'd5, 15'h0102, 32'h0, 1, 1, 32'h9ABC1234, 1'b0);
    check("lhu_after_rst", 64'(last_rdata), 64'h00009ABC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
